// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter that lets NReq requesters share one ALU. A request is
//   accepted into a single response slot. The result is computed from the
//   latched operands and held on rsp_* until the consumer takes it. When the
//   consumer takes a response and a new request is accepted in the same
//   cycle, the block sustains one operation per cycle.
//
// Parameters
//   XLen  operand/result width
//   NReq  number of requesters (2..8)
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   req_valid_i   per-requester operation valid               [NReq]
//   req_ready_o   per-requester accept, one-hot or zero       [NReq]
//   req_a_i       operand A, requester i at [i*XLen +: XLen]  [NReq*XLen]
//   req_b_i       operand B, same packing                     [NReq*XLen]
//   req_op_i      op code, requester i at [i*3 +: 3]          [NReq*3]
//   rsp_valid_o   response valid
//   rsp_ready_i   response consumer ready
//   rsp_id_o      index of the requester that issued the response
//   rsp_result_o  ALU result
//   rsp_zero_o    result equals zero
//   rsp_err_o     op code was reserved
module alu_arbiter #(
  parameter int XLen = 32,
  parameter int NReq = 2,
  localparam int OpWidth = 3,
  localparam int IdWidth = (NReq > 2) ? $clog2(NReq) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NReq-1:0]         req_valid_i,
  output logic [NReq-1:0]         req_ready_o,
  input  logic [NReq*XLen-1:0]    req_a_i,
  input  logic [NReq*XLen-1:0]    req_b_i,
  input  logic [NReq*OpWidth-1:0] req_op_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IdWidth-1:0]      rsp_id_o,
  output logic [XLen-1:0]         rsp_result_o,
  output logic                    rsp_zero_o,
  output logic                    rsp_err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [IdWidth:0]   LpNReq    = (IdWidth+1)'(NReq);
  localparam logic [IdWidth-1:0] LpLastIdx = IdWidth'(NReq - 1);

  localparam logic [OpWidth-1:0] OpAdd = 3'b000;
  localparam logic [OpWidth-1:0] OpSub = 3'b001;
  localparam logic [OpWidth-1:0] OpAnd = 3'b010;
  localparam logic [OpWidth-1:0] OpOr  = 3'b011;
  localparam logic [OpWidth-1:0] OpSlt = 3'b101;

  state_e               r_state;
  state_e               w_state_next;
  logic [IdWidth-1:0]   r_rr_ptr;
  logic [XLen-1:0]      r_a;
  logic [XLen-1:0]      r_b;
  logic [OpWidth-1:0]   r_op;
  logic [IdWidth-1:0]   r_id;

  logic                 w_slot_open;
  logic [2*NReq-1:0]    w_valid_dbl;
  logic [NReq-1:0]      w_valid_rot;
  logic                 w_found;
  logic [IdWidth:0]     w_off;
  logic [IdWidth:0]     w_sum;
  logic [IdWidth-1:0]   w_grant_idx;
  logic [IdWidth-1:0]   w_ptr_next;
  logic                 w_accept;

  logic [XLen-1:0]      w_a_arr  [NReq];
  logic [XLen-1:0]      w_b_arr  [NReq];
  logic [OpWidth-1:0]   w_op_arr [NReq];

  logic [XLen-1:0]      w_result;
  logic                 w_err;

  // Unpack the flat request buses so the grant index can select directly.
  for (genvar gi = 0; gi < NReq; gi++) begin : g_unpack
    assign w_a_arr[gi]  = req_a_i[gi*XLen +: XLen];
    assign w_b_arr[gi]  = req_b_i[gi*XLen +: XLen];
    assign w_op_arr[gi] = req_op_i[gi*OpWidth +: OpWidth];
  end

  // Gating with rst_ni keeps req_ready_o low while reset is held, even though
  // the state register already reads IDLE.
  assign w_slot_open = rst_ni & ((r_state == IDLE) | rsp_ready_i);

  // Rotate the valid vector so bit 0 corresponds to rr_ptr. The lowest set
  // bit of the rotated vector is then the round-robin winner.
  assign w_valid_dbl = {req_valid_i, req_valid_i};
  assign w_valid_rot = w_valid_dbl[r_rr_ptr +: NReq];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    // Descending scan so the lowest offset is the one left standing.
    for (int k = NReq - 1; k >= 0; k--) begin
      if (w_valid_rot[k]) begin
        w_found = 1'b1;
        w_off   = (IdWidth+1)'(k);
      end
    end
  end

  // Undo the rotation: (rr_ptr + offset) mod NReq.
  assign w_sum       = {1'b0, r_rr_ptr} + w_off;
  assign w_grant_idx = (w_sum >= LpNReq) ? IdWidth'(w_sum - LpNReq) : IdWidth'(w_sum);
  assign w_ptr_next  = (w_grant_idx == LpLastIdx) ? '0 : w_grant_idx + IdWidth'(1);
  assign w_accept    = w_slot_open & w_found;

  for (genvar gi = 0; gi < NReq; gi++) begin : g_ready
    assign req_ready_o[gi] = w_accept & (w_grant_idx == IdWidth'(gi));
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        // Staying in RESP on a same-cycle accept gives back-to-back responses.
        if (rsp_ready_i && !w_accept) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_id     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a      <= w_a_arr[w_grant_idx];
        r_b      <= w_b_arr[w_grant_idx];
        r_op     <= w_op_arr[w_grant_idx];
        r_id     <= w_grant_idx;
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  // The single shared ALU works on the latched operands only, so the response
  // stays stable while it is held.
  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_op)
      OpAdd: w_result = r_a + r_b;
      OpSub: w_result = r_a - r_b;
      OpAnd: w_result = r_a & r_b;
      OpOr:  w_result = r_a | r_b;
      // A signed compare is immune to the overflow that a subtract-and-check-
      // sign implementation would suffer.
      OpSlt: w_result = {{(XLen-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      default: begin
        w_result = '0;
        w_err    = 1'b1;
      end
    endcase
  end

  assign rsp_valid_o  = (r_state == RESP);
  assign rsp_id_o     = r_id;
  assign rsp_result_o = w_result;
  assign rsp_zero_o   = (w_result == '0);
  assign rsp_err_o    = w_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter with XLen=32, NReq=2. Inputs change on
//   the falling edge; outputs are sampled 1 ns after the falling edge.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  int n_pass  = 0;
  int n_total = 0;

  alu_arbiter #(.XLen(32), .NReq(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .rsp_err_o    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*3 +: 3]  = op;
    req_valid[i]      = 1'b1;
  endtask

  // One isolated request from requester i with the consumer always ready.
  task automatic single(input string tag, input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op,
                        input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_err);
    logic [1:0] exp_rdy;
    exp_rdy = 2'b01 << i;
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    set_req(i, a, b, op);
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({tag, ".no_rsp_yet"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".id"}, 32'(rsp_id), 32'(i));
    chk({tag, ".result"}, rsp_result, exp_res);
    chk({tag, ".zero"}, 32'(rsp_zero), 32'(exp_zero));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    #1;
    chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    $display("txn %s: req%0d a=0x%08h b=0x%08h op=%03b -> result=0x%08h zero=%0b err=%0b",
             tag, i, a, b, op, rsp_result, rsp_zero, rsp_err);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;

    // Reset state: nothing granted even with both requesters valid.
    repeat (2) @(negedge clk);
    #1;
    chk("reset.ready", 32'(req_ready), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.id", 32'(rsp_id), 32'd0);
    chk("reset.result", rsp_result, 32'd0);
    chk("reset.zero", 32'(rsp_zero), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Pointer starts at 0 and advances past each granted requester.
    single("sub",       0, 32'd5,        32'd3,        3'b001, 32'd2,        1'b0, 1'b0);
    single("slt_ovf1",  1, 32'h80000000, 32'h00000001, 3'b101, 32'd1,        1'b0, 1'b0);
    single("slt_ovf0",  0, 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b101, 32'd0,        1'b1, 1'b0);
    single("reserved",  1, 32'h0000FFFF, 32'h00000001, 3'b110, 32'd0,        1'b1, 1'b1);
    single("add_wrap",  0, 32'hFFFFFFFF, 32'd2,        3'b000, 32'd1,        1'b0, 1'b0);
    single("or",        1, 32'h000000F0, 32'h0000000F, 3'b011, 32'h000000FF, 1'b0, 1'b0);
    single("and",       0, 32'h0000FF00, 32'h00000FF0, 3'b010, 32'h00000F00, 1'b0, 1'b0);
    single("sub_wrap",  1, 32'd3,        32'd5,        3'b001, 32'hFFFFFFFE, 1'b0, 1'b0);
    single("rsv_111",   0, 32'd7,        32'd7,        3'b111, 32'd0,        1'b1, 1'b1);

    // Fresh reset, then both requesters valid with the consumer always ready:
    // grants alternate and a response is presented every cycle.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 32'd10, 32'd1, 3'b000);  // 11
    set_req(1, 32'd10, 32'd1, 3'b001);  // 9
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("alt%0d.ready", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        chk($sformatf("alt%0d.rsp_valid", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("alt%0d.id", k), 32'(rsp_id), 32'((k - 1) % 2));
        chk($sformatf("alt%0d.result", k), rsp_result, ((k - 1) % 2 == 0) ? 32'd11 : 32'd9);
      end
      $display("txn alt%0d: ready=%02b rsp_valid=%0b id=%0d result=%0d",
               k, req_ready, rsp_valid, rsp_id, rsp_result);
      @(negedge clk);
    end

    // Backpressure: the response from requester 0 is held for 4 cycles.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp%0d.ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d.rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d.id", k), 32'(rsp_id), 32'd0);
      chk($sformatf("bp%0d.result", k), rsp_result, 32'd11);
      $display("txn bp%0d: held id=%0d result=%0d ready=%02b", k, rsp_id, rsp_result, req_ready);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release.ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("bp_next.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next.id", 32'(rsp_id), 32'd1);
    chk("bp_next.result", rsp_result, 32'd9);
    $display("txn bp_next: id=%0d result=%0d", rsp_id, rsp_result);
    @(negedge clk);
    #1;
    chk("bp_drain.rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset while a response is held: leave the pointer at 1 first.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(0, 32'd4, 32'd4, 3'b000);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rst_resp.held", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_resp.async_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp.ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_resp.no_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_resp.id", 32'(rsp_id), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("rst_resp.grant0", 32'(req_ready), 32'd1);
    $display("txn rst_resp: after release ready=%02b rsp_valid=%0b", req_ready, rsp_valid);
    @(negedge clk);
    req_valid = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLen, default 32, operand/result width.
REQ-002 Parameter NReq, default 2, number of requesters (2..8).
REQ-003 Derived widths: OpWidth = 3; IdWidth = max(1, $clog2(NReq)).
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 req_valid_i  in  NReq  per-requester operation valid.
REQ-007 req_ready_o  out  NReq  per-requester accept; at most one bit high per cycle.
REQ-008 req_a_i  in  NReq*XLen  operand A, requester i at bits [i*XLen +: XLen].
REQ-009 req_b_i  in  NReq*XLen  operand B, same packing.
REQ-010 req_op_i  in  NReq*3  op code, requester i at bits [i*3 +: 3].
REQ-011 rsp_valid_o  out  1  response valid.
REQ-012 rsp_ready_i  in  1  response consumer ready.
REQ-013 rsp_id_o  out  IdWidth  index of the requester that issued the response.
REQ-014 rsp_result_o  out  XLen  ALU result.
REQ-015 rsp_zero_o  out  1  high when rsp_result_o == 0.
REQ-016 rsp_err_o  out  1  high when the op code was reserved.

Function
REQ-017 Op codes: 000 add, 001 sub (a-b), 010 and, 011 or, 101 signed set-less-than (result 1 or 0, overflow-corrected); 100, 110, 111 reserved.
REQ-018 Reserved op: result 0, zero 1, err 1; response still issued normally.
REQ-019 Block SHALL contain exactly one ALU datapath shared by all requesters; add/sub wrap modulo 2^XLen.
REQ-020 FSM states IDLE (no response held) and RESP (response held on rsp_* outputs).
REQ-021 Accept slot open when state is IDLE, or state is RESP and rsp_ready_i is high in the same cycle.
REQ-022 When slot open, grant goes to the first requester with req_valid_i high, searching i = rr_ptr, rr_ptr+1, ... mod NReq; req_ready_o is high only for that requester.
REQ-023 When slot closed, req_ready_o is all zeros regardless of req_valid_i.
REQ-024 On accept (req_valid_i[i] & req_ready_o[i]): latch a, b, op and id = i; rr_ptr <= (i+1) mod NReq; state <= RESP.
REQ-025 rr_ptr unchanged in cycles with no accept.
REQ-026 Latency: rsp_valid_o rises exactly one cycle after accept; rsp_* computed from latched operands.
REQ-027 While rsp_valid_o is high and rsp_ready_i is low, all rsp_* outputs remain stable.
REQ-028 Response handshake with no accept in the same cycle: state <= IDLE, rsp_valid_o low next cycle.
REQ-029 Response handshake with simultaneous accept: state stays RESP and the new response is presented next cycle (sustained throughput 1 op/cycle).
REQ-030 Requesters may drop req_valid_i without a handshake; no accept occurs.
REQ-031 req_ready_o may depend combinationally on req_valid_i and rsp_ready_i; rsp_* outputs are registered or derived only from registered state.

Reset
REQ-032 On rst_ni low: state IDLE, rr_ptr 0, latched a/b/op/id 0, rsp_valid_o 0, req_ready_o all 0 during reset.
REQ-033 Reset asserted while in RESP discards the pending response; no response is issued after release.
REQ-034 First cycle after release: grant search starts at requester 0.

Verification
REQ-035 Single request: req0 a=5 b=3 op=001 -> accepted cycle T, rsp_valid_o at T+1, result 2, id 0, zero 0, err 0.
REQ-036 SLT overflow case, XLen=32: a=0x80000000 b=0x00000001 op=101 -> result 1; a=0x7FFFFFFF b=0xFFFFFFFF op=101 -> result 0.
REQ-037 Both requesters valid continuously, rsp_ready_i=1, after reset -> grants alternate 0,1,0,1 on consecutive cycles; responses every cycle.
REQ-038 Backpressure: rsp_ready_i=0 for 4 cycles while response held -> rsp_* stable, req_ready_o all 0; on rsp_ready_i=1, next request accepted same cycle.
REQ-039 Reserved op 110, a=0xFFFF b=0x1 -> result 0, zero 1, err 1.
REQ-040 Reset asserted while in RESP -> rsp_valid_o 0 immediately (asynchronously), no response after release, next grant to requester 0.
